bus_timer: RTL and testbench

BUS_TIMER -- requirements
Module: bus_timer

---
 rtl/bus_timer_pkg.sv | 30 +++
 rtl/bus_timer.sv | 158 +++++++++++++++
 tb/tb_bus_timer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_timer_pkg.sv
// Shared definitions for bus_timer: FSM states, register offsets, CTRL field positions
// and MODE encodings. Imported by the timer, the CPU bridge and the testbench.
package bus_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } bt_state_e;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONE_SHOT    = 2'b00;
    localparam logic [1:0] MODE_AUTO_RELOAD = 2'b01;

    // MODE 1x behaves as one-shot, so only the exact auto-reload code counts.
    function automatic logic mode_is_auto(input logic [1:0] mode);
        return mode == MODE_AUTO_RELOAD;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with CTRL/PRESET/COUNT registers and an interrupt.
// Define BUS_TIMER_IRQ_EN to build the IM bit, the pending flag and the irq output.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for ENABLE; COUNT holds its last value
// ST_LOAD | copy PRESET into COUNT
// ST_CNT  | decrement COUNT; leave on disable or when COUNT reaches 1/0
// ST_INT  | terminal count: one-shot clears ENABLE, auto-reload re-arms
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    if (ADDR_BASE[1:0] != 2'b00) begin : g_base_check
        $error("bus_timer: ADDR_BASE must be word aligned");
    end

    logic        ctrl_en_q, ctrl_en_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    bt_state_e   state_q, state_d;
    logic        wr_ctrl, wr_preset;
    logic        fsm_clr_en;
    logic        im_rd;

    assign wr_ctrl   = sel & we & (addr == OFF_CTRL);
    assign wr_preset = sel & we & (addr == OFF_PRESET);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        fsm_clr_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en_q) begin
                    state_d = ST_IDLE;
                end else if (count_q <= 32'd1) begin
                    // Saturate at zero so a PRESET of 0 never wraps.
                    count_d = 32'd0;
                    state_d = ST_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            ST_INT: begin
                state_d    = ST_IDLE;
                fsm_clr_en = ~mode_is_auto(mode_q);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A CPU write to CTRL overrides the FSM clearing ENABLE on the same edge.
    always_comb begin
        ctrl_en_d = ctrl_en_q & ~fsm_clr_en;
        mode_d    = mode_q;
        preset_d  = preset_q;
        if (wr_ctrl) begin
            ctrl_en_d = wdata[CTRL_EN_BIT];
            mode_d    = wdata[CTRL_MODE_MSB:CTRL_MODE_LSB];
        end
        if (wr_preset) preset_d = wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en_q <= 1'b0;
            mode_q    <= MODE_ONE_SHOT;
            preset_q  <= 32'd0;
        end else begin
            ctrl_en_q <= ctrl_en_d;
            mode_q    <= mode_d;
            preset_q  <= preset_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef BUS_TIMER_IRQ_EN
    logic im_q, im_d;
    logic pend_q, pend_d;
    logic pend_set, pend_drop;

    // Pending rises on entry to ST_INT; auto-reload drops it again on exit.
    assign pend_set  = (state_q == ST_CNT) & ctrl_en_q & (count_q <= 32'd1);
    assign pend_drop = (state_q == ST_INT) & mode_is_auto(mode_q);

    always_comb begin
        im_d   = wr_ctrl ? wdata[CTRL_IM_BIT] : im_q;
        pend_d = pend_q;
        if (wr_ctrl | wr_preset) pend_d = 1'b0;
        if (pend_set) begin
            pend_d = 1'b1;
        end else if (pend_drop) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            im_q   <= im_d;
            pend_q <= pend_d;
        end
    end

    assign irq   = pend_q & im_q;
    assign im_rd = im_q;
`else
    assign irq   = 1'b0;
    assign im_rd = 1'b0;
`endif

    always_comb begin
        rdata = 32'd0;
        case (addr)
            OFF_CTRL: begin
                rdata[CTRL_EN_BIT]                 = ctrl_en_q;
                rdata[CTRL_MODE_MSB:CTRL_MODE_LSB] = mode_q;
                rdata[CTRL_IM_BIT]                 = im_rd;
            end
            OFF_PRESET: rdata = preset_q;
            OFF_COUNT:  rdata = count_q;
            OFF_RSVD:   rdata = 32'd0;
            default:    rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: timeline model compared every cycle, directed
// scenarios with literal expectations, then randomized register traffic and resets.
module tb_bus_timer;
    import bus_timer_pkg::*;

`ifdef BUS_TIMER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    bus_timer dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    // Timeline view of the timer: a run starts one edge after ENABLE is seen idle,
    // position 0 loads, positions 1..L count (L = max(loaded,1)), position L+1 fires.
    typedef struct packed {
        logic        en;
        logic [1:0]  mode;
        logic        im;
        logic [31:0] preset;
        logic [31:0] count;
        logic [31:0] loaded;
        logic        pend;
        logic        busy;
        logic [32:0] pos;
    } model_t;

    model_t m;

    function automatic model_t step(model_t cur, logic s, logic w, logic [1:0] a, logic [31:0] d);
        model_t n;
        logic wr_c, wr_p;
        logic [32:0] run_len;
        n       = cur;
        wr_c    = s && w && (a == OFF_CTRL);
        wr_p    = s && w && (a == OFF_PRESET);
        run_len = {1'b0, (cur.loaded <= 32'd1) ? 32'd1 : cur.loaded};
        if (wr_c || wr_p) n.pend = 1'b0;
        if (!cur.busy) begin
            if (cur.en) begin
                n.busy = 1'b1;
                n.pos  = 33'd0;
            end
        end else if (cur.pos == 33'd0) begin
            n.loaded = cur.preset;
            n.count  = cur.preset;
            n.pos    = 33'd1;
        end else if (cur.pos <= run_len) begin
            if (!cur.en) begin
                n.busy = 1'b0;
            end else if (cur.pos == run_len) begin
                n.count = 32'd0;
                n.pos   = run_len + 33'd1;
                if (IRQ_ON) n.pend = 1'b1;
            end else begin
                n.count = cur.loaded - cur.pos[31:0];
                n.pos   = cur.pos + 33'd1;
            end
        end else begin
            n.busy = 1'b0;
            if (cur.mode == MODE_AUTO_RELOAD) n.pend = 1'b0;
            else n.en = 1'b0;
        end
        if (wr_c) begin
            n.en   = d[0];
            n.mode = d[2:1];
            n.im   = IRQ_ON & d[3];
        end
        if (wr_p) n.preset = d;
        return n;
    endfunction

    function automatic logic [31:0] mread(model_t cur, logic [1:0] a);
        case (a)
            OFF_CTRL:   return {28'd0, cur.im, cur.mode, cur.en};
            OFF_PRESET: return cur.preset;
            OFF_COUNT:  return cur.count;
            default:    return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) m <= '0;
        else m <= step(m, sel, we, addr, wdata);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    endtask

    always @(negedge clk) begin
        chk("cmp_rdata", rdata, mread(m, addr));
        chk("cmp_irq", 32'(irq), 32'(m.pend & m.im));
    end

    task automatic cyc(input logic s, input logic w, input logic [1:0] a, input logic [31:0] d);
        sel = s; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; we = 1'b0;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cyc(1'b1, 1'b1, a, d);
    endtask

    task automatic idle(input int n, input logic [1:0] a);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, 32'd0);
    endtask

    task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
        sel = 1'b1; we = 1'b0; addr = a;
        #1;
        chk(name, rdata, exp);
        @(posedge clk); #1;
        sel = 1'b0;
        #1;
    endtask

    logic [31:0] s31_cnt [1:5] = '{32'd0, 32'd3, 32'd2, 32'd1, 32'd0};

    initial begin
        logic [31:0] d;
        int r;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        #1;

        rd_chk("rst_ctrl", OFF_CTRL, 32'd0);
        rd_chk("rst_preset", OFF_PRESET, 32'd0);
        rd_chk("rst_count", OFF_COUNT, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);

        // Read-only COUNT and the reserved slot ignore writes.
        wr(OFF_COUNT, 32'h55);
        wr(OFF_RSVD, 32'hFF);
        rd_chk("ro_count", OFF_COUNT, 32'd0);
        rd_chk("rsvd_zero", OFF_RSVD, 32'd0);

        // One-shot, PRESET=3: irq 5 edges after the CTRL write, sticky until CTRL write.
        wr(OFF_PRESET, 32'd3);
        wr(OFF_CTRL, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            idle(1, OFF_COUNT);
            chk("os_count", rdata, s31_cnt[k]);
            chk("os_irq", 32'(irq), 32'(IRQ_ON && (k == 5)));
        end
        idle(1, OFF_COUNT);
        rd_chk("os_ctrl_after", OFF_CTRL, IRQ_ON ? 32'h8 : 32'h0);
        chk("os_irq_sticky", 32'(irq), 32'(IRQ_ON));
        idle(3, OFF_COUNT);
        chk("os_irq_hold", 32'(irq), 32'(IRQ_ON));
        chk("os_count_zero", rdata, 32'd0);
        wr(OFF_CTRL, 32'h0);
        chk("os_irq_clear", 32'(irq), 32'd0);

        // Auto-reload, PRESET=2: IDLE,LOAD,CNT,CNT,INT repeats every 5 edges.
        wr(OFF_PRESET, 32'd2);
        wr(OFF_CTRL, 32'hB);
        for (int k = 1; k <= 16; k++) begin
            idle(1, OFF_COUNT);
            chk("ar_irq", 32'(irq), 32'(IRQ_ON && (k % 5 == 4)));
            chk("ar_count", rdata, (k % 5 == 2) ? 32'd2 : (k % 5 == 3) ? 32'd1 : 32'd0);
        end
        wr(OFF_CTRL, 32'h0);

        // Disable mid-count freezes COUNT; re-enable reloads from PRESET.
        wr(OFF_PRESET, 32'd10);
        wr(OFF_CTRL, 32'h1);
        idle(4, OFF_COUNT);
        wr(OFF_CTRL, 32'h0);
        rd_chk("frz_count", OFF_COUNT, 32'd7);
        rd_chk("frz_hold", OFF_COUNT, 32'd7);
        wr(OFF_CTRL, 32'h1);
        rd_chk("rel_idle", OFF_COUNT, 32'd7);
        rd_chk("rel_load", OFF_COUNT, 32'd7);
        rd_chk("rel_count", OFF_COUNT, 32'd10);
        wr(OFF_CTRL, 32'h0);

        // PRESET=0 saturates at zero and fires without wrapping.
        wr(OFF_PRESET, 32'd0);
        wr(OFF_CTRL, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            idle(1, OFF_COUNT);
            if (k >= 2) chk("p0_count", rdata, 32'd0);
            chk("p0_irq", 32'(irq), 32'(IRQ_ON && (k >= 3)));
        end
        rd_chk("p0_ctrl", OFF_CTRL, IRQ_ON ? 32'h8 : 32'h0);
        wr(OFF_CTRL, 32'h0);

        // Reset while counting aborts everything.
        wr(OFF_PRESET, 32'd5);
        wr(OFF_CTRL, 32'h9);
        idle(3, OFF_COUNT);
        reset = 1'b0;
        #1;
        chk("rstmid_irq", 32'(irq), 32'd0);
        rd_chk("rstmid_ctrl", OFF_CTRL, 32'd0);
        rd_chk("rstmid_preset", OFF_PRESET, 32'd0);
        rd_chk("rstmid_count", OFF_COUNT, 32'd0);
        rd_chk("rstmid_rsvd", OFF_RSVD, 32'd0);
        reset = 1'b1;
        #1;
        rd_chk("rstmid_after", OFF_CTRL, 32'd0);
        idle(8, OFF_COUNT);
        chk("rstmid_noirq", 32'(irq), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 6) begin
                d = $urandom;
                d[0] = ($urandom_range(0, 3) != 0);
                wr(OFF_CTRL, d);
            end else if (r < 10) begin
                wr(OFF_PRESET, $urandom_range(0, 12));
            end else if (r < 12) begin
                wr(2'($urandom_range(2, 3)), $urandom);
            end else if (r < 13) begin
                reset = 1'b0;
                idle(2, OFF_CTRL);
                reset = 1'b1;
                #1;
            end else begin
                cyc(1'b1, 1'b0, 2'($urandom_range(0, 3)), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
